// File: rtl/risac_bus_arbiter_if.sv
// Bundle of the three Avalon-MM links around the bus arbiter: the fetch
// port (avIB), the data port (avDB) and the shared master port (avM).
// The slave modport is the arbiter's view; the master modport is the view
// of everything attached around it (core wrapper and interconnect).
interface risac_bus_arbiter_if;
   logic [31:0] avIB_address;
   logic        avIB_read;
   logic [31:0] avIB_readdata;
   logic        avIB_waitrequest;

   logic [31:0] avDB_address;
   logic        avDB_read;
   logic        avDB_write;
   logic [31:0] avDB_writedata;
   logic [3:0]  avDB_byteenable;
   logic [31:0] avDB_readdata;
   logic        avDB_waitrequest;

   logic [31:0] avM_address;
   logic        avM_read;
   logic        avM_write;
   logic [31:0] avM_writedata;
   logic [3:0]  avM_byteenable;
   logic [31:0] avM_readdata;
   logic        avM_waitrequest;

   modport slave (
      input  avIB_address, avIB_read,
      output avIB_readdata, avIB_waitrequest,
      input  avDB_address, avDB_read, avDB_write, avDB_writedata, avDB_byteenable,
      output avDB_readdata, avDB_waitrequest,
      output avM_address, avM_read, avM_write, avM_writedata, avM_byteenable,
      input  avM_readdata, avM_waitrequest
   );

   modport master (
      output avIB_address, avIB_read,
      input  avIB_readdata, avIB_waitrequest,
      output avDB_address, avDB_read, avDB_write, avDB_writedata, avDB_byteenable,
      input  avDB_readdata, avDB_waitrequest,
      input  avM_address, avM_read, avM_write, avM_writedata, avM_byteenable,
      output avM_readdata, avM_waitrequest
   );
endinterface

// File: rtl/risac_bus_arbiter.sv
// Shares one Avalon-MM master between the risac fetch and data buses.
// Data has priority, but after MAX_D_STREAK consecutive data grants a
// pending fetch wins. An optional watchdog terminates transfers that stall
// for TIMEOUT cycles, returning ERR_DATA and setting a sticky error flag.
module risac_bus_arbiter #(
   parameter int unsigned MAX_D_STREAK = 4,
   parameter int unsigned TIMEOUT      = 0,
   parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
   input  logic                        clk,
   input  logic                        rst,
   risac_bus_arbiter_if.slave          bus,
   output logic                        oGrantI,
   output logic                        oGrantD,
   output logic                        oBusErr
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);
   localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT);
   localparam bit          WD_EN      = (TIMEOUT != 0);

   state_t      state_q, state_d;
   logic [3:0]  streak_q, streak_d;
   logic [15:0] wd_cnt_q, wd_cnt_d;
   logic        bus_err_q, bus_err_d;

   logic req_i, req_d, owner_req, other_req;
   logic stalled, timeout, done, win_d, entry;

   // Request decode, completion/timeout detection and next-state selection.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves a variable unassigned and no latch is inferred.
      state_d   = state_q;
      streak_d  = streak_q;
      wd_cnt_d  = wd_cnt_q;
      bus_err_d = bus_err_q;

      req_i     = bus.avIB_read;
      req_d     = bus.avDB_read | bus.avDB_write;
      owner_req = ((state_q == GNT_I) && req_i) || ((state_q == GNT_D) && req_d);
      other_req = (state_q == GNT_I) ? req_d : req_i;
      stalled   = owner_req && bus.avM_waitrequest;
      timeout   = WD_EN && stalled && (wd_cnt_q == WD_LIMIT);
      done      = owner_req && (!bus.avM_waitrequest || timeout);
      // Data wins a contested arbitration unless it has used up its streak.
      win_d     = req_d && (!req_i || (streak_q != STREAK_MAX));

      case (state_q)
         IDLE: begin
            if (win_d)      state_d = GNT_D;
            else if (req_i) state_d = GNT_I;
         end
         default: begin
            if (!owner_req)
               state_d = IDLE;
            else if (done)
               // With the owner still requesting, a waiting non-owner makes
               // this a contested arbitration; otherwise the bus goes idle.
               state_d = other_req ? (win_d ? GNT_D : GNT_I) : IDLE;
         end
      endcase

      entry = (state_d != IDLE) && ((state_d != state_q) || done);

      if (entry) begin
         wd_cnt_d = '0;
         if (state_d == GNT_D)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
         else
            streak_d = '0;
      end else if (WD_EN && stalled && !timeout) begin
         wd_cnt_d = wd_cnt_q + 16'd1;
      end

      bus_err_d = bus_err_q | timeout;
   end

   // Master pass-through and slave-side handshake for the current owner.
   always_comb begin
      bus.avM_address      = '0;
      bus.avM_read         = 1'b0;
      bus.avM_write        = 1'b0;
      bus.avM_writedata    = '0;
      bus.avM_byteenable   = '0;
      bus.avIB_waitrequest = 1'b1;
      bus.avDB_waitrequest = 1'b1;
      bus.avIB_readdata    = bus.avM_readdata;
      bus.avDB_readdata    = bus.avM_readdata;

      // While reset is held the master strobes drop immediately.
      if (!rst) begin
         case (state_q)
            GNT_I: begin
               bus.avM_address      = bus.avIB_address;
               bus.avM_read         = bus.avIB_read;
               bus.avM_byteenable   = 4'hF;
               bus.avIB_waitrequest = bus.avM_waitrequest;
               if (timeout) begin
                  bus.avM_read         = 1'b0;
                  bus.avIB_waitrequest = 1'b0;
                  bus.avIB_readdata    = ERR_DATA;
               end
            end
            GNT_D: begin
               bus.avM_address      = bus.avDB_address;
               bus.avM_read         = bus.avDB_read;
               bus.avM_write        = bus.avDB_write;
               bus.avM_writedata    = bus.avDB_writedata;
               bus.avM_byteenable   = bus.avDB_byteenable;
               bus.avDB_waitrequest = bus.avM_waitrequest;
               if (timeout) begin
                  bus.avM_read         = 1'b0;
                  bus.avM_write        = 1'b0;
                  bus.avDB_waitrequest = 1'b0;
                  bus.avDB_readdata    = ERR_DATA;
               end
            end
            default: ;
         endcase
      end
   end

   // State, streak, watchdog and error flag registers.
   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         wd_cnt_q  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         wd_cnt_q  <= wd_cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign oGrantI = (state_q == GNT_I);
   assign oGrantD = (state_q == GNT_D);
   assign oBusErr = bus_err_q;

endmodule

// File: tb/tb_risac_bus_arbiter.sv
// Randomized scoreboard bench for risac_bus_arbiter. A driver issues bus
// traffic and runs a transaction-level reference model that pushes the
// expected per-cycle bus view and the expected completions into queues;
// a monitor on the falling edge pops and compares what the DUT presents.
module tb_risac_bus_arbiter;
   localparam int          MAXS   = 4;
   localparam int          TO     = 8;
   localparam logic [31:0] ERRD   = 32'hDEADBEEF;
   localparam int          NCYC   = 4000;
   localparam int          NONE   = 0;
   localparam int          FETCH  = 1;
   localparam int          DATA   = 2;

   logic clk = 1'b0;
   logic rst;
   logic grant_i, grant_d, bus_err;

   always #5 clk = ~clk;

   risac_bus_arbiter_if bus ();

   risac_bus_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .oGrantI (grant_i),
      .oGrantD (grant_d),
      .oBusErr (bus_err)
   );

   typedef struct {
      bit          gi, gd, err, iw, dw, mr, mw;
      logic [31:0] ma, mwd;
      logic [3:0]  mbe;
   } cyc_t;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } cpl_t;

   cyc_t cyc_q[$];
   cpl_t cpl_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: who owns the bus, how many data grants in a row,
   // how long the current transfer has stalled, and the sticky error.
   int owner  = NONE;
   int d_run  = 0;
   int stall  = 0;
   bit err_m  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arbitration rule: data first, unless the data streak is exhausted
   // while a fetch is waiting.
   function automatic int winner(input bit want_i, input bit want_d);
      if (want_d && (!want_i || d_run != MAXS)) return DATA;
      if (want_i) return FETCH;
      return NONE;
   endfunction

   // Monitor: compare the DUT's visible bus state against the model.
   always @(negedge clk) begin
      cyc_t e;
      cpl_t c;
      if (cyc_q.size() != 0) begin
         e = cyc_q.pop_front();
         check("grant_i",  64'(grant_i), 64'(e.gi));
         check("grant_d",  64'(grant_d), 64'(e.gd));
         check("bus_err",  64'(bus_err), 64'(e.err));
         check("ib_wait",  64'(bus.avIB_waitrequest), 64'(e.iw));
         check("db_wait",  64'(bus.avDB_waitrequest), 64'(e.dw));
         check("m_read",   64'(bus.avM_read),  64'(e.mr));
         check("m_write",  64'(bus.avM_write), 64'(e.mw));
         if (e.mr || e.mw) begin
            check("m_addr",  64'(bus.avM_address),    64'(e.ma));
            check("m_be",    64'(bus.avM_byteenable), 64'(e.mbe));
            check("m_wdata", 64'(bus.avM_writedata),  64'(e.mwd));
         end
         if (bus.avIB_read && !bus.avIB_waitrequest) begin
            if (cpl_q.size() == 0) check("unexpected_fetch_done", 64'd1, 64'd0);
            else begin
               c = cpl_q.pop_front();
               check("done_port_fetch", 64'(c.is_d), 64'd0);
               check("fetch_rdata", 64'(bus.avIB_readdata), 64'(c.data));
            end
         end
         if ((bus.avDB_read || bus.avDB_write) && !bus.avDB_waitrequest) begin
            if (cpl_q.size() == 0) check("unexpected_data_done", 64'd1, 64'd0);
            else begin
               c = cpl_q.pop_front();
               check("done_port_data", 64'(c.is_d), 64'd1);
               check("data_rdata", 64'(bus.avDB_readdata), 64'(c.data));
            end
         end
      end
   end

   // Driver: random masters and slave, plus the reference model.
   initial begin
      bit ib_act = 0, db_act = 0, ib_done = 0, db_done = 0;
      int stuck = 0;
      cyc_t e;
      cpl_t c;
      bit busy, fire, finished, dreq, fresh;
      int nxt;

      rst = 1'b1;
      bus.avIB_address = '0; bus.avIB_read = 1'b0;
      bus.avDB_address = '0; bus.avDB_read = 1'b0; bus.avDB_write = 1'b0;
      bus.avDB_writedata = '0; bus.avDB_byteenable = '0;
      bus.avM_readdata = '0; bus.avM_waitrequest = 1'b0;
      repeat (2) @(posedge clk);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         // Masters retire a completed transfer, then may issue a new one.
         if (ib_done) begin ib_act = 0; bus.avIB_read = 1'b0; end
         if (db_done) begin db_act = 0; bus.avDB_read = 1'b0; bus.avDB_write = 1'b0; end
         ib_done = 0; db_done = 0;
         if (ib_act && $urandom_range(0, 149) == 0) begin
            ib_act = 0; bus.avIB_read = 1'b0;
         end
         if (db_act && $urandom_range(0, 149) == 0) begin
            db_act = 0; bus.avDB_read = 1'b0; bus.avDB_write = 1'b0;
         end
         if (!ib_act && $urandom_range(0, 99) < 50) begin
            ib_act = 1;
            bus.avIB_address = {$urandom_range(0, 65535), 2'b00} & 32'h3FFFC;
            bus.avIB_read    = 1'b1;
         end
         if (!db_act && $urandom_range(0, 99) < 85) begin
            int op;
            db_act = 1;
            op = $urandom_range(0, 19);
            bus.avDB_read       = (op < 10) || (op == 19);
            bus.avDB_write      = (op >= 10);
            bus.avDB_address    = $urandom;
            bus.avDB_writedata  = $urandom;
            bus.avDB_byteenable = 4'($urandom_range(1, 15));
         end

         // Slave behaviour, with occasional long stalls to reach the watchdog.
         if (stuck == 0 && $urandom_range(0, 59) == 0) stuck = 12;
         if (cyc == 2000) stuck = 12;
         if (stuck > 0) begin
            stuck--;
            bus.avM_waitrequest = 1'b1;
         end else begin
            bus.avM_waitrequest = ($urandom_range(0, 99) < 30);
         end
         bus.avM_readdata = $urandom;

         rst = (cyc < 2) || (cyc == 2004) || ($urandom_range(0, 399) == 0);

         // Expected visible behaviour for this cycle.
         e = '{default: '0};
         e.gi = (owner == FETCH); e.gd = (owner == DATA); e.err = err_m;
         e.iw = 1'b1; e.dw = 1'b1;
         dreq = bus.avDB_read || bus.avDB_write;

         if (rst) begin
            owner = NONE; d_run = 0; stall = 0; err_m = 1'b0;
         end else begin
            busy = (owner == FETCH) ? bus.avIB_read : (owner == DATA) ? dreq : 1'b0;
            if (owner == FETCH) begin
               e.ma = bus.avIB_address; e.mr = bus.avIB_read; e.mbe = 4'hF;
               e.iw = bus.avM_waitrequest;
            end else if (owner == DATA) begin
               e.ma = bus.avDB_address; e.mr = bus.avDB_read; e.mw = bus.avDB_write;
               e.mwd = bus.avDB_writedata; e.mbe = bus.avDB_byteenable;
               e.dw = bus.avM_waitrequest;
            end
            fire = (TO > 0) && busy && bus.avM_waitrequest && (stall == TO);
            if (fire) begin
               e.mr = 1'b0; e.mw = 1'b0;
               if (owner == FETCH) e.iw = 1'b0; else e.dw = 1'b0;
            end
            finished = busy && (!bus.avM_waitrequest || fire);
            if (finished) begin
               c.is_d = (owner == DATA);
               c.data = fire ? ERRD : bus.avM_readdata;
               cpl_q.push_back(c);
               if (owner == FETCH) ib_done = 1; else db_done = 1;
            end

            if (owner == NONE)   nxt = winner(bus.avIB_read, dreq);
            else if (!busy)      nxt = NONE;
            else if (finished)   nxt = ((owner == FETCH) ? dreq : bus.avIB_read) ? winner(1'b1, 1'b1) : NONE;
            else                 nxt = owner;

            fresh = (nxt != NONE) && (nxt != owner || finished);
            if (fresh) begin
               stall = 0;
               d_run = (nxt == DATA) ? ((d_run < MAXS) ? d_run + 1 : MAXS) : 0;
            end else if (busy && bus.avM_waitrequest) begin
               stall++;
            end
            err_m = err_m | fire;
            owner = nxt;
         end
         cyc_q.push_back(e);
      end

      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.avIB_read = 1'b0; bus.avDB_read = 1'b0; bus.avDB_write = 1'b0;
      @(negedge clk);
      #1;
      check("pending_cycle_records", 64'(cyc_q.size()), 64'd0);
      check("pending_completions", 64'(cpl_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
